// File: rtl/proc_pkg.sv
// proc_pkg: shared widths, ROM op codes and arbiter FSM encoding for the ROM access path.
package proc_pkg;
  localparam int DATA_WIDTH = 16;
  localparam int ROM_WORD_W = 32;
  localparam logic [3:0] ROM_OP = 4'b0011;
  localparam logic [1:0] DR_DIRECT = 2'd1;
  localparam logic [1:0] DR_INDIRECT = 2'd2;
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_READ    = 2'd1,
    S_CAPTURE = 2'd2,
    S_RESP    = 2'd3
  } state_e;
endpackage

// File: rtl/rom_arb_pick.sv
// rom_arb_pick: one-hot grant select between fetch (bit 0) and data-read (bit 1); ROM_ARB_ROUND_ROBIN_EN adds the pointer.
module rom_arb_pick (
  input  logic       if_valid,
  input  logic       dr_valid,
`ifdef ROM_ARB_ROUND_ROBIN_EN
  input  logic       ptr,
`endif
  output logic [1:0] grant
);
`ifdef ROM_ARB_ROUND_ROBIN_EN
  assign grant[0] = if_valid & (~dr_valid | ~ptr);
  assign grant[1] = dr_valid & (~if_valid | ptr);
`else
  assign grant[0] = if_valid;
  assign grant[1] = dr_valid & ~if_valid;
`endif
endmodule

// File: rtl/rom_access_arbiter.sv
// rom_access_arbiter: shares one ROM port between fetch and data-read channels; ROM_ARB_ROUND_ROBIN_EN selects round-robin ties.
module rom_access_arbiter import proc_pkg::*; #(
  parameter int DATA_WIDTH = proc_pkg::DATA_WIDTH,
  parameter int ROM_DEPTH  = 257
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req_valid,
  input  logic [DATA_WIDTH-1:0] if_req_addr,
  output logic                  if_req_ready,
  output logic                  if_rsp_valid,
  output logic [DATA_WIDTH-1:0] if_rsp_opcode,
  output logic [DATA_WIDTH-1:0] if_rsp_operand,
  input  logic                  dr_req_valid,
  input  logic [DATA_WIDTH-1:0] dr_req_addr,
  output logic                  dr_req_ready,
  output logic                  dr_rsp_valid,
  output logic [DATA_WIDTH-1:0] dr_rsp_data,
  output logic                  rsp_err,
  output logic                  rom_en,
  output logic [DATA_WIDTH-1:0] rom_addr,
  input  logic [31:0]           rom_rdata,
  output logic                  busy
);
  localparam logic [DATA_WIDTH:0] DEPTH = (DATA_WIDTH+1)'(ROM_DEPTH);
  state_e state_q, state_d;
  logic ch_q, ch_d, err_q, err_d;
  logic rom_en_q, rom_en_d;
  logic [DATA_WIDTH-1:0] rom_addr_q, rom_addr_d;
  logic if_rsp_valid_q, if_rsp_valid_d, dr_rsp_valid_q, dr_rsp_valid_d, rsp_err_q, rsp_err_d;
  logic [DATA_WIDTH-1:0] opcode_q, opcode_d, operand_q, operand_d, dr_data_q, dr_data_d;
  logic [1:0] grant;
  logic idle, hs, hs_dr, req_err, cap;
  logic [DATA_WIDTH-1:0] req_addr;
  logic [31:0] word;
`ifdef ROM_ARB_ROUND_ROBIN_EN
  logic ptr_q, ptr_d;
  rom_arb_pick u_pick (.if_valid(if_req_valid), .dr_valid(dr_req_valid), .ptr(ptr_q), .grant(grant));
  assign ptr_d = hs ? ~hs_dr : ptr_q;
  always_ff @(posedge clk)
    if (rst) ptr_q <= 1'b0;
    else ptr_q <= ptr_d;
`else
  rom_arb_pick u_pick (.if_valid(if_req_valid), .dr_valid(dr_req_valid), .grant(grant));
`endif
  assign idle         = state_q == S_IDLE;
  assign if_req_ready = idle & grant[0] & ~rst;
  assign dr_req_ready = idle & grant[1] & ~rst;
  assign hs_dr        = dr_req_valid & dr_req_ready;
  assign hs           = (if_req_valid & if_req_ready) | hs_dr;
  assign req_addr     = hs_dr ? dr_req_addr : if_req_addr;
  assign req_err      = {1'b0, req_addr} >= DEPTH;
  assign cap          = state_q == S_CAPTURE;
  // Out-of-range requests never strobe the ROM, so their response word is forced to zero.
  assign word         = err_q ? '0 : rom_rdata;
  always_comb begin
    state_d        = idle ? (hs ? S_READ : S_IDLE)
                   : state_q == S_READ ? S_CAPTURE
                   : cap ? S_RESP : S_IDLE;
    ch_d           = hs ? hs_dr : ch_q;
    err_d          = hs ? req_err : err_q;
    rom_en_d       = hs & ~req_err;
    rom_addr_d     = (hs & ~req_err) ? req_addr : rom_addr_q;
    if_rsp_valid_d = cap & ~ch_q;
    dr_rsp_valid_d = cap & ch_q;
    rsp_err_d      = cap & err_q;
    opcode_d       = (cap & ~ch_q) ? DATA_WIDTH'(word[31:16]) : opcode_q;
    operand_d      = (cap & ~ch_q) ? DATA_WIDTH'(word[15:0]) : operand_q;
    dr_data_d      = (cap & ch_q) ? DATA_WIDTH'(word[15:0]) : dr_data_q;
  end
  always_ff @(posedge clk)
    if (rst) begin
      state_q        <= S_IDLE;
      ch_q           <= 1'b0;
      err_q          <= 1'b0;
      rom_en_q       <= 1'b0;
      rom_addr_q     <= '0;
      if_rsp_valid_q <= 1'b0;
      dr_rsp_valid_q <= 1'b0;
      rsp_err_q      <= 1'b0;
      opcode_q       <= '0;
      operand_q      <= '0;
      dr_data_q      <= '0;
    end else begin
      state_q        <= state_d;
      ch_q           <= ch_d;
      err_q          <= err_d;
      rom_en_q       <= rom_en_d;
      rom_addr_q     <= rom_addr_d;
      if_rsp_valid_q <= if_rsp_valid_d;
      dr_rsp_valid_q <= dr_rsp_valid_d;
      rsp_err_q      <= rsp_err_d;
      opcode_q       <= opcode_d;
      operand_q      <= operand_d;
      dr_data_q      <= dr_data_d;
    end
  assign busy           = ~idle;
  assign rom_en         = rom_en_q;
  assign rom_addr       = rom_addr_q;
  assign if_rsp_valid   = if_rsp_valid_q;
  assign dr_rsp_valid   = dr_rsp_valid_q;
  assign rsp_err        = rsp_err_q;
  assign if_rsp_opcode  = opcode_q;
  assign if_rsp_operand = operand_q;
  assign dr_rsp_data    = dr_data_q;
endmodule

// File: doc/rom_access_arbiter.md
ROM_ACCESS_ARBITER -- requirements
Module: rom_access_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 16: width of opcode, operand, data and address fields.
REQ-002 Parameter ROM_DEPTH, default 257: number of valid ROM words; addresses 0..ROM_DEPTH-1 are legal.
REQ-003 Port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 Port rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 Port if_req_valid  input  1  instruction-fetch request pending.
REQ-006 Port if_req_addr  input  DATA_WIDTH  instruction-fetch word address.
REQ-007 Port if_req_ready  output  1  arbiter accepts the fetch request this cycle.
REQ-008 Port if_rsp_valid  output  1  one-cycle pulse: fetch response valid.
REQ-009 Port if_rsp_opcode  output  DATA_WIDTH  ROM word bits [31:16].
REQ-010 Port if_rsp_operand  output  DATA_WIDTH  ROM word bits [15:0].
REQ-011 Port dr_req_valid / dr_req_addr / dr_req_ready  in/in/out  1/DATA_WIDTH/1  data-read request channel; same rules as the fetch channel.
REQ-012 Port dr_rsp_valid  output  1  one-cycle pulse: data-read response valid.
REQ-013 Port dr_rsp_data  output  DATA_WIDTH  ROM word bits [15:0].
REQ-014 Port rsp_err  output  1  qualifies the current rsp_valid pulse: the address was out of range.
REQ-015 Port rom_en / rom_addr  output  1/DATA_WIDTH  ROM read strobe and address.
REQ-016 Port rom_rdata  input  32  ROM word; valid in the cycle after rom_en is high.
REQ-017 Port busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-018 FSM states: IDLE, READ, CAPTURE, RESP.
- IDLE -> READ on a request handshake.
- READ -> CAPTURE unconditionally.
- CAPTURE -> RESP unconditionally.
- RESP -> IDLE unconditionally.
REQ-019 Ready is asserted only in IDLE, and only on the granted channel; the handshake is valid&&ready in that cycle.
REQ-020 On a handshake, the address, the granted channel, and the range check (addr >= ROM_DEPTH) are registered.
REQ-021 In READ:
- in-range: rom_en=1 and rom_addr=captured address.
- out-of-range: rom_en=0.
REQ-022 In CAPTURE, rom_rdata is registered; for an out-of-range request, zero is registered instead.
REQ-023 In RESP, exactly one of if_rsp_valid or dr_rsp_valid is high (per the registered channel) for one cycle, and rsp_err equals the registered range flag.
REQ-024 Latency: the response pulse appears 3 cycles after the handshake cycle; maximum throughput is one request per 4 cycles.
REQ-025 Responses have no backpressure; response data outputs hold their value until the next RESP.
REQ-026 Requesters keep valid and addr stable until ready; if valid drops before ready, no request is issued.
REQ-027 When only one channel is valid in IDLE, it is granted.
REQ-028 When both channels are valid in IDLE, arbitration follows REQ-033/REQ-034.
REQ-029 Reset in any state aborts the operation: no response pulse is issued and the FSM enters IDLE.

Reset
REQ-030 On rst, the following are cleared to 0: state=IDLE, busy, both ready outputs, both rsp_valid outputs, rsp_err, rom_en, rom_addr, all response data, and the round-robin pointer (pointer = fetch-favoured).
REQ-031 While rst is high, no request is accepted, even if valid is high.

Configuration
REQ-032 Macro ROM_ARB_ROUND_ROBIN_EN selects the arbitration policy.
REQ-033 With ROM_ARB_ROUND_ROBIN_EN defined:
- on a simultaneous request, grant the channel not granted last;
- the pointer updates only on a handshake;
- after reset, fetch wins the first tie.
REQ-034 Without ROM_ARB_ROUND_ROBIN_EN: fixed priority, fetch always wins ties; no pointer register is present.

Structure
REQ-035 Shared package proc_pkg holds DATA_WIDTH, the ROM word width (32), the ROM op nibble 4'b0011, the data-read subcodes (1: direct, 2: address-indirect), and the FSM state encoding.
REQ-036 One sub-module, rom_arb_pick: a combinational grant select (two valids plus pointer -> one-hot grant), whose internals are conditioned on the macro.

Verification
REQ-037 Single fetch: if addr=0x0005, ROM[5]=0x3100_0042 -> if_rsp_valid pulses 3 cycles after the handshake with opcode=0x3100, operand=0x0042, rsp_err=0.
REQ-038 Single data read: dr addr=0x0010, ROM[16]=0xDEAD_BEEF -> dr_rsp_data=0xBEEF, dr_rsp_valid pulse, if_rsp_valid stays 0.
REQ-039 Out of range: dr addr=0x0101 (257) -> rom_en never rises, dr_rsp_data=0x0000, rsp_err=1.
REQ-040 Both channels continuously valid for 4 grants:
- with the macro, grant order is IF, DR, IF, DR;
- without the macro, grant order is IF, IF, IF, IF.
REQ-041 rst asserted in CAPTURE -> no rsp_valid pulse; the next cycle shows busy=0 and the IDLE state; a new request then completes normally.
REQ-042 Back-to-back fetches at addr 1 and 2 -> handshakes are 4 cycles apart, and the responses arrive in order with correct data.
